// File: rtl/mem_io_responder.sv
// rtl/mem_io_responder.sv - byte RAM plus UART/halt IO responder for the CPU memory port
module mem_io_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int TX_DEPTH   = 8,
    parameter int TX_WIDTH   = 3,
    parameter int RX_DEPTH   = 4,
    parameter int RX_WIDTH   = 2,
    parameter int FULL_SLACK = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_dout,
    input  logic        mem_wr,
    output logic [7:0]  mem_din,
    output logic        io_buffer_full,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        halt,
    output logic        tx_overflow
);
    localparam int TXC_W = TX_WIDTH + 1;
    localparam int RXC_W = RX_WIDTH + 1;
    localparam logic [TX_WIDTH:0] TX_FULL = TXC_W'(TX_DEPTH);
    localparam logic [TX_WIDTH:0] TX_HIGH = TXC_W'(TX_DEPTH - FULL_SLACK);
    localparam logic [RX_WIDTH:0] RX_FULL = RXC_W'(RX_DEPTH);
    localparam logic [17:0] UART_ADDR = 18'h30000;
    localparam logic [17:0] STAT_ADDR = 18'h30004;

    logic [7:0]          r_mem [0:(2**ADDR_WIDTH)-1];
    logic [7:0]          r_tx_buf [0:TX_DEPTH-1];
    logic [7:0]          r_rx_buf [0:RX_DEPTH-1];
    logic [TX_WIDTH-1:0] r_tx_rd, r_tx_wr;
    logic [TX_WIDTH:0]   r_tx_count;
    logic [RX_WIDTH-1:0] r_rx_rd, r_rx_wr;
    logic [RX_WIDTH:0]   r_rx_count;
    logic [7:0]          r_mem_din;
    logic                r_io_full, r_halt, r_tx_ovf;

    logic                w_is_io, w_uart, w_stat, w_cpu_wr, w_cpu_rd;
    logic                w_tx_push, w_tx_pop, w_tx_drop, w_rx_push, w_rx_pop;
    logic [TX_WIDTH:0]   w_tx_count_next;
    logic                w_unused;

    assign w_unused = ^mem_a[31:18];

    assign w_is_io  = (mem_a[17:16] == 2'b11);
    assign w_uart   = (mem_a[17:0] == UART_ADDR);
    assign w_stat   = (mem_a[17:0] == STAT_ADDR);
    assign w_cpu_wr = rdy_in && mem_wr;
    assign w_cpu_rd = rdy_in && !mem_wr;

    // Fullness is judged on the count before any same-cycle drain.
    assign w_tx_push = w_cpu_wr && w_uart && (r_tx_count != TX_FULL);
    assign w_tx_drop = w_cpu_wr && w_uart && (r_tx_count == TX_FULL);
    assign w_tx_pop  = (r_tx_count != '0) && tx_ready;
    assign w_rx_push = rx_valid && (r_rx_count != RX_FULL);
    assign w_rx_pop  = w_cpu_rd && w_uart && (r_rx_count != '0);

    assign w_tx_count_next = r_tx_count + TXC_W'(w_tx_push) - TXC_W'(w_tx_pop);

    assign mem_din        = r_mem_din;
    assign io_buffer_full = r_io_full;
    assign tx_valid       = (r_tx_count != '0);
    assign tx_data        = r_tx_buf[r_tx_rd];
    assign rx_ready       = (r_rx_count != RX_FULL);
    assign halt           = r_halt;
    assign tx_overflow    = r_tx_ovf;

    // Storage arrays carry no reset; only pointers/counts define FIFO contents.
    always_ff @(posedge clk_in) begin
        if (w_cpu_wr && !w_is_io)
            r_mem[mem_a[ADDR_WIDTH-1:0]] <= mem_dout;
        if (w_tx_push)
            r_tx_buf[r_tx_wr] <= mem_dout;
        if (w_rx_push)
            r_rx_buf[r_rx_wr] <= rx_data;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_tx_rd    <= '0;
            r_tx_wr    <= '0;
            r_tx_count <= '0;
            r_rx_rd    <= '0;
            r_rx_wr    <= '0;
            r_rx_count <= '0;
            r_mem_din  <= '0;
            r_io_full  <= 1'b0;
            r_halt     <= 1'b0;
            r_tx_ovf   <= 1'b0;
        end else begin
            if (w_tx_push)
                r_tx_wr <= r_tx_wr + TX_WIDTH'(1);
            if (w_tx_pop)
                r_tx_rd <= r_tx_rd + TX_WIDTH'(1);
            r_tx_count <= w_tx_count_next;
            r_io_full  <= (w_tx_count_next >= TX_HIGH);

            if (w_rx_push)
                r_rx_wr <= r_rx_wr + RX_WIDTH'(1);
            if (w_rx_pop)
                r_rx_rd <= r_rx_rd + RX_WIDTH'(1);
            r_rx_count <= r_rx_count + RXC_W'(w_rx_push) - RXC_W'(w_rx_pop);

            if (w_tx_drop)
                r_tx_ovf <= 1'b1;
            if (w_cpu_wr && w_stat)
                r_halt <= 1'b1;

            if (w_cpu_rd) begin
                if (!w_is_io)
                    r_mem_din <= r_mem[mem_a[ADDR_WIDTH-1:0]];
                else if (w_uart)
                    r_mem_din <= (r_rx_count != '0) ? r_rx_buf[r_rx_rd] : 8'h00;
                else if (w_stat)
                    r_mem_din <= {7'b0, r_halt};
                else
                    r_mem_din <= 8'h00;
            end
        end
    end
endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Memory-side responder for the CPU's byte-serial memory port (mem_a / mem_dout / mem_wr / mem_din) driven by the load-store buffer.
- Serves byte RAM below 0x30000 and memory-mapped IO at 0x30000 (UART data) and 0x30004 (halt / status).
- Buffers outgoing UART bytes in a TX FIFO and drives io_buffer_full back to the CPU.
- Buffers incoming bytes in an RX FIFO that is popped by loads from 0x30000.

Parameters:
- ADDR_WIDTH, 17, RAM address bits (2^ADDR_WIDTH bytes).
- TX_DEPTH, 8, TX FIFO entries.
- TX_WIDTH, 3, log2(TX_DEPTH).
- RX_DEPTH, 4, RX FIFO entries.
- RX_WIDTH, 2, log2(RX_DEPTH).
- FULL_SLACK, 2, free TX entries reserved when io_buffer_full asserts.

Ports:
- clk_in  input  1  clock, all state on posedge.
- rst_in  input  1  reset, asynchronous, active-low.
- rdy_in  input  1  CPU-side enable; low freezes CPU-side accesses.
- mem_a  input  32  byte address from CPU.
- mem_dout  input  8  write data from CPU.
- mem_wr  input  1  1 = write, 0 = read.
- mem_din  output  8  read data to CPU (registered).
- io_buffer_full  output  1  TX FIFO near full (registered).
- tx_valid  output  1  TX byte available.
- tx_data  output  8  TX FIFO head byte.
- tx_ready  input  1  sink accepts TX byte.
- rx_valid  input  1  RX byte offered.
- rx_data  input  8  RX byte.
- rx_ready  output  1  RX FIFO can accept.
- halt  output  1  sticky; program wrote 0x30004.
- tx_overflow  output  1  sticky; a UART write was dropped.

Behaviour:
- Reset (rst_in=0, async): mem_din=0, io_buffer_full=0, both FIFOs empty (pointers and counts 0), tx_valid=0, rx_ready=1, halt=0, tx_overflow=0. RAM contents are not reset.
- A reset mid-transfer discards all FIFO contents.
- Decode: mem_a[17:16]==2'b11 selects IO. Otherwise RAM, indexed by mem_a[ADDR_WIDTH-1:0]. Upper address bits are ignored.
- Per cycle, rdy_in=1, mem_wr=1:
  - RAM: mem[addr] <= mem_dout.
  - 0x30000: push mem_dout into TX FIFO if tx_count < TX_DEPTH (count before any same-cycle pop). Otherwise drop the byte and set tx_overflow.
  - 0x30004: set halt.
  - Other IO addresses: ignored.
- Per cycle, rdy_in=1, mem_wr=0:
  - RAM: mem_din <= mem[addr] at the next edge (read latency 1 cycle).
  - 0x30000: if RX nonempty, mem_din <= RX head and pop. If empty, mem_din <= 0, no pop.
  - 0x30004: mem_din <= {7'b0, halt}.
  - Other IO addresses: mem_din <= 0.
- Each read cycle is a new access. The address is held for consecutive cycles only by the requester; no internal burst state.
- rdy_in=0:
  - No RAM write, no CPU-side FIFO push or pop, mem_din holds.
  - TX drain and RX fill continue.
- TX handshake:
  - tx_valid = (tx_count != 0); tx_data = TX head.
  - Pop when tx_valid && tx_ready.
  - tx_data is stable while tx_valid && !tx_ready.
- RX handshake:
  - rx_ready = (rx_count != RX_DEPTH).
  - Push when rx_valid && rx_ready.
- Simultaneous push and pop on the same FIFO in one cycle: both occur, count unchanged. Pointers wrap modulo DEPTH.
- io_buffer_full <= (tx_count_next >= TX_DEPTH - FULL_SLACK), registered. The slack absorbs one in-flight store plus the one-cycle flag latency.
- halt and tx_overflow clear only on reset.

Test Plan:
- RAM write/read: write 0xA5 @0x00010 (rdy_in=1), then read 0x00010 → mem_din=0xA5 exactly one cycle after the read address; read 0x00011 (never written) next cycle → that byte's prior contents with the same latency.
- TX fill: tx_ready=0, write 0x41..0x46 to 0x30000 → io_buffer_full=1 on the edge after the 6th push; tx_valid=1, tx_data=0x41. Raise tx_ready → bytes drain in order 0x41..0x46; io_buffer_full drops once count<6.
- Overflow: tx_ready=0, 9 writes to 0x30000 → 9th dropped, tx_overflow=1, FIFO holds first 8.
- RX path: offer 0x30,0x31 via rx_valid; two reads of 0x30000 → mem_din 0x30 then 0x31; third read → 0x00, count stays 0. Fill 4 entries → rx_ready=0.
- Halt/status: write 0x30004 → halt=1 next edge; read 0x30004 → mem_din=0x01.
- rdy_in low and reset: with rdy_in=0, write to 0x30000 → no push, mem_din holds. Assert rst_in low mid-drain → tx_valid, halt, io_buffer_full fall to 0 immediately (async).
